// File: rtl/fp_add_seq.sv
// rtl/fp_add_seq.sv - multi-cycle positive-operand single-precision adder (IDLE/ALIGN/ADD/NORM/DONE).
// Define FP_ADD_SEQ_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_add_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] dataR,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic [7:0]  exp_q, exp_d;
  logic [23:0] mant_big_q, mant_big_d;
  logic [23:0] mant_small_q, mant_small_d;
  logic [24:0] sum_q, sum_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
`ifdef FP_ADD_SEQ_ROUND_EN
  logic        grd_q, grd_d;
  logic        rnd_q, rnd_d;
  logic        stk_q, stk_d;
  logic        norm_g, norm_r, norm_s, round_up;
  logic [24:0] rounded;
`endif

  logic [7:0]  exp_a, exp_b, diff;
  logic [23:0] man_a, man_b;
  logic        a_ge, a_zero, b_zero, any_inf;
  logic [8:0]  norm_exp;
  logic [23:0] norm_mant;
  logic [31:0] norm_res;
  logic        unused_bits;

  assign exp_a   = dataA[30:23];
  assign exp_b   = dataB[30:23];
  assign man_a   = {1'b1, dataA[22:0]};
  assign man_b   = {1'b1, dataB[22:0]};
  assign a_ge    = (exp_a >= exp_b);
  assign diff    = a_ge ? (exp_a - exp_b) : (exp_b - exp_a);
  assign a_zero  = (exp_a == 8'd0);
  assign b_zero  = (exp_b == 8'd0);
  assign any_inf = (exp_a == 8'hFF) || (exp_b == 8'hFF);

  assign in_ready    = (state_q == S_IDLE) && armed_q;
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign dataR       = res_q;
  assign unused_bits = ^{dataA[31], dataB[31], norm_mant[23]};

  // Normalisation: positive operands with hidden 1s can only carry out, never need a left shift.
  always_comb begin
    norm_exp  = {1'b0, exp_q};
    norm_mant = sum_q[23:0];
    if (sum_q[24]) begin
      norm_mant = sum_q[24:1];
      norm_exp  = norm_exp + 9'd1;
    end
`ifdef FP_ADD_SEQ_ROUND_EN
    norm_g   = sum_q[24] ? sum_q[0] : grd_q;
    norm_r   = sum_q[24] ? grd_q : rnd_q;
    norm_s   = sum_q[24] ? (rnd_q | stk_q) : stk_q;
    round_up = norm_g & (norm_r | norm_s | norm_mant[0]);
    rounded  = {1'b0, norm_mant} + {24'd0, round_up};
    if (rounded[24]) begin
      norm_mant = rounded[24:1];
      norm_exp  = norm_exp + 9'd1;
    end else begin
      norm_mant = rounded[23:0];
    end
`endif
    norm_res = (norm_exp >= 9'd255) ? 32'h7F80_0000
                                    : {1'b0, norm_exp[7:0], norm_mant[22:0]};
  end

  always_comb begin
    state_d      = state_q;
    armed_d      = 1'b1;
    exp_d        = exp_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
`ifdef FP_ADD_SEQ_ROUND_EN
    grd_d        = grd_q;
    rnd_d        = rnd_q;
    stk_d        = stk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && armed_q) begin
          if (any_inf) begin
            res_d   = 32'h7F80_0000;
            state_d = S_DONE;
          end else if (a_zero) begin
            res_d   = {1'b0, dataB[30:0]};
            state_d = S_DONE;
          end else if (b_zero) begin
            res_d   = {1'b0, dataA[30:0]};
            state_d = S_DONE;
          end else if (diff >= 8'd25) begin
            res_d   = a_ge ? {1'b0, dataA[30:0]} : {1'b0, dataB[30:0]};
            state_d = S_DONE;
          end else begin
            exp_d        = a_ge ? exp_a : exp_b;
            mant_big_d   = a_ge ? man_a : man_b;
            mant_small_d = a_ge ? man_b : man_a;
            cnt_d        = diff[4:0];
`ifdef FP_ADD_SEQ_ROUND_EN
            grd_d        = 1'b0;
            rnd_d        = 1'b0;
            stk_d        = 1'b0;
`endif
            state_d      = (diff == 8'd0) ? S_ADD : S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        mant_small_d = mant_small_q >> 1;
        cnt_d        = cnt_q - 5'd1;
`ifdef FP_ADD_SEQ_ROUND_EN
        grd_d        = mant_small_q[0];
        rnd_d        = grd_q;
        stk_d        = stk_q | rnd_q;
`endif
        if (cnt_q == 5'd1) state_d = S_ADD;
      end
      S_ADD: begin
        sum_d   = {1'b0, mant_big_q} + {1'b0, mant_small_q};
        state_d = S_NORM;
      end
      S_NORM: begin
        res_d   = norm_res;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      armed_q      <= 1'b0;
      exp_q        <= 8'd0;
      mant_big_q   <= 24'd0;
      mant_small_q <= 24'd0;
      sum_q        <= 25'd0;
      cnt_q        <= 5'd0;
      res_q        <= 32'd0;
`ifdef FP_ADD_SEQ_ROUND_EN
      grd_q        <= 1'b0;
      rnd_q        <= 1'b0;
      stk_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      exp_q        <= exp_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
`ifdef FP_ADD_SEQ_ROUND_EN
      grd_q        <= grd_d;
      rnd_q        <= rnd_d;
      stk_q        <= stk_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// tb/tb_fp_add_seq.sv - randomized self-checking bench for fp_add_seq against an exact-arithmetic model.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dataA = 32'd0;
  logic [31:0] dataB = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dataR;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fp_add_seq dut (
    .clk(clk), .rst(rst), .dataA(dataA), .dataB(dataB), .in_valid(in_valid),
    .in_ready(in_ready), .dataR(dataR), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact sum as an integer, then normalise to 24 bits and round from the true remainder.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output int lat);
    int ea, eb, eg, d, nb, sh, e;
    longint unsigned mg, ms, tot, rem, half, mant;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    lat = 1;
    if (ea == 255 || eb == 255) begin r = 32'h7F800000; return; end
    if (ea == 0) begin r = {1'b0, b[30:0]}; return; end
    if (eb == 0) begin r = {1'b0, a[30:0]}; return; end
    if (ea >= eb) begin
      eg = ea; d = ea - eb;
      mg = longint'({1'b1, a[22:0]}); ms = longint'({1'b1, b[22:0]});
    end else begin
      eg = eb; d = eb - ea;
      mg = longint'({1'b1, b[22:0]}); ms = longint'({1'b1, a[22:0]});
    end
    if (d >= 25) begin r = (ea >= eb) ? {1'b0, a[30:0]} : {1'b0, b[30:0]}; return; end
    lat = (d == 0) ? 3 : d + 3;
    tot = (mg << d) + ms;
    nb = 0;
    for (int i = 0; i < 64; i++) if (tot[i]) nb = i + 1;
    sh   = nb - 24;
    mant = tot >> sh;
    rem  = tot & ((64'd1 << sh) - 64'd1);
    e    = eg + sh - d;
`ifdef FP_ADD_SEQ_ROUND_EN
    if (sh > 0) begin
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 1;
      if (mant == (64'd1 << 24)) begin mant = mant >> 1; e = e + 1; end
    end
`else
    half = rem;
`endif
    if (e >= 255) r = 32'h7F800000;
    else r = {1'b0, 8'(e), mant[22:0]};
  endfunction

  // Issue one operation at a negedge, measure latency, hold out_ready low, then hand-shake.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_lat, input int hold);
    int lat;
    logic [31:0] held;
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    dataA = a; dataB = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 64) begin
      in_valid = 1'($urandom); dataA = $urandom; dataB = $urandom;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'($urandom); dataA = $urandom; dataB = $urandom;
    check({tag, " result"}, dataR, exp_r);
    check({tag, " latency"}, lat, exp_lat);
    held = dataR;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_valid = 1'($urandom); dataA = $urandom;
      check({tag, " hold"}, {dataR[31:1], dataR[0] ^ out_valid ^ in_ready},
            {held[31:1], held[0] ^ 1'b1});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, " return"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  function automatic logic [31:0] rand_operand(input int near_exp);
    int sel, e;
    sel = $urandom_range(0, 15);
    if (sel == 0) return 32'h0;
    if (sel == 1) return {1'($urandom), 8'hFF, 23'($urandom)};
    if (sel == 2) e = $urandom_range(1, 254);
    else e = near_exp + $urandom_range(0, 26) - 13;
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    return {1'($urandom), 8'(e), 23'($urandom)};
  endfunction

  logic [31:0] ra, rb, rr;
  int rl, ov_seen, ea0;

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset state", {dataR[31:0]}, 32'd0);
    check("reset flags", {29'd0, in_ready, out_valid, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready after reset", {31'd0, in_ready}, 32'd1);

    run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000, 3, 0);
    run_op("one_plus_half", 32'h3F800000, 32'h3F000000, 32'h3FC00000, 4, 1);
    run_op("far_d30", 32'h3F800000, 32'h30800000, 32'h3F800000, 1, 0);
    run_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3, 0);
`ifdef FP_ADD_SEQ_ROUND_EN
    run_op("d24_round", 32'h3F800000, 32'h33C00000, 32'h3F800001, 27, 0);
`else
    run_op("d24_trunc", 32'h3F800000, 32'h33C00000, 32'h3F800000, 27, 0);
`endif
    run_op("b_is_zero", 32'hC0490FDB, 32'h00000000, 32'h40490FDB, 1, 0);
    run_op("a_is_inf", 32'h7F800000, 32'h3F800000, 32'h7F800000, 1, 0);
    run_op("hold5", 32'h3F800000, 32'h3F000000, 32'h3FC00000, 4, 5);

    for (int i = 0; i < 60; i++) begin
      ea0 = (i % 10 == 0) ? 250 : $urandom_range(1, 254);
      ra = rand_operand(ea0);
      rb = rand_operand(ea0);
      ref_model(ra, rb, rr, rl);
      run_op("random", ra, rb, rr, rl, $urandom_range(0, 3));
    end

    check("ready before abort", {31'd0, in_ready}, 32'd1);
    dataA = 32'h3F800000; dataB = 32'h33C00000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("busy in align", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort flags", {29'd0, in_ready, out_valid, busy}, 32'd0);
    check("abort dataR", dataR, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready after abort", {31'd0, in_ready}, 32'd1);
    ov_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1;
    end
    check("no result after abort", ov_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
